// File: rtl/morse_pkg.sv
// morse_pkg: shared types and constants for the Morse receive path.
//   state_t      decoder FSM state encoding
//   SYM_*        symbol bit values stored in the shift register
//   thresholds   mark/space run-length limits in tick units
//   LC_*         3-bit letter codes shared with the transmitter path
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARK    = 2'd1,
    ST_SPACE   = 2'd2,
    ST_ERRWAIT = 2'd3
  } state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int DASH_MIN   = 2;
  localparam int DASH_MAX   = 3;
  localparam int LETTER_GAP = 3;
  localparam int MAX_SYM    = 4;

  localparam logic [2:0] LC_S = 3'd0;
  localparam logic [2:0] LC_T = 3'd1;
  localparam logic [2:0] LC_U = 3'd2;
  localparam logic [2:0] LC_V = 3'd3;
  localparam logic [2:0] LC_W = 3'd4;
  localparam logic [2:0] LC_X = 3'd5;
  localparam logic [2:0] LC_Y = 3'd6;
  localparam logic [2:0] LC_Z = 3'd7;

endpackage

// File: rtl/morse_pattern_lut.sv
// morse_pattern_lut: combinational symbol-sequence to letter-code lookup.
//   i_nsym        number of symbols collected (0..4)
//   i_sym         symbols, oldest in the highest used bit, 1 = dash
//   o_lettercode  decoded letter code (LC_S when no hit)
//   o_hit         1 when the sequence is one of S..Z
module morse_pattern_lut
  import morse_pkg::*;
(
  input  logic [2:0] i_nsym,
  input  logic [3:0] i_sym,
  output logic [2:0] o_lettercode,
  output logic       o_hit
);

  // Only the low i_nsym bits are significant; unused upper bits are ignored.
  always_comb begin
    o_lettercode = LC_S;
    o_hit        = 1'b0;
    case (i_nsym)
      3'd1: begin
        if (i_sym[0] == SYM_DASH) begin
          o_lettercode = LC_T;
          o_hit        = 1'b1;
        end
      end
      3'd3: begin
        case (i_sym[2:0])
          3'b000:  begin o_lettercode = LC_S; o_hit = 1'b1; end
          3'b001:  begin o_lettercode = LC_U; o_hit = 1'b1; end
          3'b011:  begin o_lettercode = LC_W; o_hit = 1'b1; end
          default: ;
        endcase
      end
      3'd4: begin
        case (i_sym)
          4'b0001: begin o_lettercode = LC_V; o_hit = 1'b1; end
          4'b1001: begin o_lettercode = LC_X; o_hit = 1'b1; end
          4'b1011: begin o_lettercode = LC_Y; o_hit = 1'b1; end
          4'b1100: begin o_lettercode = LC_Z; o_hit = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: Morse receiver for letters S..Z, sampled once per tick.
//   clock       system clock
//   reset       asynchronous, active-high
//   tick        unit-time strobe; din is sampled only when tick = 1
//   din         keyed line, 1 = mark
//   lettercode  last decoded letter, held between letters
//   valid       one-cycle pulse when lettercode is updated
//   error       one-cycle pulse on a malformed letter
// Optional: define MORSE_DEC_ERR_EN to report malformed letters on error;
// without it error is 0, any mark of 2+ units is a dash and bad letters
// are dropped silently.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting for the first mark of a letter
// ST_MARK    | counting mark units
// ST_SPACE   | counting space units after a symbol
// ST_ERRWAIT | letter discarded; waiting for a clean 3-unit gap
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       din,
  output logic [2:0] lettercode,
  output logic       valid,
  output logic       error
);

  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_DASH_MIN = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] L_GAP      = CNT_W'(LETTER_GAP);
  localparam logic [2:0]       L_MAX_SYM  = 3'(MAX_SYM);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_mark_cnt, w_mark_nx;
  logic [CNT_W-1:0] r_space_cnt, w_space_nx, w_space_inc;
  logic [3:0]       r_sym, w_sym_nx;
  logic [2:0]       r_nsym, w_nsym_nx;
  logic [2:0]       r_lettercode, w_lc_nx;
  logic             r_valid, w_valid_nx;
  logic [2:0]       w_lut_code;
  logic             w_lut_hit;
  logic             w_is_dash;
  logic             w_abort;

  morse_pattern_lut u_lut (
    .i_nsym       (r_nsym),
    .i_sym        (r_sym),
    .o_lettercode (w_lut_code),
    .o_hit        (w_lut_hit)
  );

  assign w_is_dash   = (r_mark_cnt >= L_DASH_MIN);
  assign w_space_inc = r_space_cnt + L_ONE;

`ifdef MORSE_DEC_ERR_EN
  localparam logic [CNT_W-1:0] L_DASH_MAX = CNT_W'(DASH_MAX);
  logic r_error, w_error_nx;
  // A saturated mark count is still above DASH_MAX, so it aborts too.
  assign w_abort = (r_mark_cnt > L_DASH_MAX) || (r_nsym == L_MAX_SYM);
  assign error   = r_error;
`else
  assign w_abort = (r_nsym == L_MAX_SYM);
  assign error   = 1'b0;
`endif

  assign lettercode = r_lettercode;
  assign valid      = r_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mark_cnt   <= '0;
      r_space_cnt  <= '0;
      r_sym        <= '0;
      r_nsym       <= '0;
      r_lettercode <= LC_S;
      r_valid      <= 1'b0;
`ifdef MORSE_DEC_ERR_EN
      r_error      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_mark_cnt   <= w_mark_nx;
      r_space_cnt  <= w_space_nx;
      r_sym        <= w_sym_nx;
      r_nsym       <= w_nsym_nx;
      r_lettercode <= w_lc_nx;
      r_valid      <= w_valid_nx;
`ifdef MORSE_DEC_ERR_EN
      r_error      <= w_error_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mark_nx  = r_mark_cnt;
    w_space_nx = r_space_cnt;
    w_sym_nx   = r_sym;
    w_nsym_nx  = r_nsym;
    w_lc_nx    = r_lettercode;
    w_valid_nx = 1'b0;
`ifdef MORSE_DEC_ERR_EN
    w_error_nx = 1'b0;
`endif
    if (tick) begin
      case (r_state)
        ST_IDLE: begin
          if (din) begin
            w_state_nx = ST_MARK;
            w_mark_nx  = L_ONE;
            w_nsym_nx  = '0;
            // Clearing sym keeps unused upper bits zero for the lookup.
            w_sym_nx   = '0;
          end
        end
        ST_MARK: begin
          if (din) begin
            if (r_mark_cnt != '1) w_mark_nx = r_mark_cnt + L_ONE;
          end else if (w_abort) begin
            // The falling edge already counts as the first gap unit.
            w_state_nx = ST_ERRWAIT;
            w_space_nx = L_ONE;
`ifdef MORSE_DEC_ERR_EN
            w_error_nx = 1'b1;
`endif
          end else begin
            w_sym_nx   = {r_sym[2:0], w_is_dash};
            w_nsym_nx  = r_nsym + 3'd1;
            w_state_nx = ST_SPACE;
            w_space_nx = L_ONE;
          end
        end
        ST_SPACE: begin
          if (din) begin
            w_state_nx = ST_MARK;
            w_mark_nx  = L_ONE;
          end else begin
            w_space_nx = w_space_inc;
            if (w_space_inc == L_GAP) begin
              w_state_nx = ST_IDLE;
              if (w_lut_hit) begin
                w_lc_nx    = w_lut_code;
                w_valid_nx = 1'b1;
              end
`ifdef MORSE_DEC_ERR_EN
              else begin
                w_error_nx = 1'b1;
              end
`endif
            end
          end
        end
        ST_ERRWAIT: begin
          if (din) begin
            w_space_nx = '0;
          end else begin
            w_space_nx = w_space_inc;
            if (w_space_inc == L_GAP) w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
module tb_morse_decoder;

`ifdef MORSE_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int MARK_SAT = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic       din   = 1'b0;
  logic [2:0] lettercode;
  logic       valid;
  logic       error;

  morse_decoder #(.CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .din        (din),
    .lettercode (lettercode),
    .valid      (valid),
    .error      (error)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int n_valid_seen = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: works on run lengths and a dot/dash string.
  string codes [8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  int    m_mode;   // 0 waiting, 1 in mark, 2 in gap, 3 discarding
  int    m_mark;
  int    m_space;
  string m_syms;
  int    e_lc;
  logic  e_valid, e_error;

  function automatic int lookup(input string s);
    for (int i = 0; i < 8; i++) if (s == codes[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_mark = 0; m_space = 0; m_syms = "";
    e_lc = 0; e_valid = 1'b0; e_error = 1'b0;
  endtask

  task automatic model_tick(input logic d);
    int k;
    e_valid = 1'b0;
    e_error = 1'b0;
    case (m_mode)
      0: if (d) begin m_mode = 1; m_mark = 1; m_syms = ""; end
      1: begin
        if (d) begin
          if (m_mark < MARK_SAT) m_mark++;
        end else begin
          m_space = 1;
          if ((ERR_EN && m_mark >= 4) || m_syms.len() == 4) begin
            e_error = ERR_EN;
            m_mode  = 3;
          end else begin
            if (m_mark >= 2) m_syms = {m_syms, "-"};
            else             m_syms = {m_syms, "."};
            m_mode = 2;
          end
        end
      end
      2: begin
        if (d) begin
          m_mode = 1; m_mark = 1;
        end else begin
          m_space++;
          if (m_space == 3) begin
            k = lookup(m_syms);
            if (k >= 0) begin e_lc = k; e_valid = 1'b1; end
            else e_error = ERR_EN;
            m_mode = 0;
          end
        end
      end
      default: begin
        if (d) m_space = 0;
        else begin
          m_space++;
          if (m_space == 3) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input logic t, input logic d);
    tick = t;
    din  = d;
    @(posedge clock);
    if (t) model_tick(d);
    else begin e_valid = 1'b0; e_error = 1'b0; end
    #1;
    check("valid", int'(valid), int'(e_valid));
    check("error", int'(error), int'(e_error));
    check("lettercode", int'(lettercode), e_lc);
    if (valid) n_valid_seen++;
  endtask

  task automatic send_bits(input string bits);
    for (int i = 0; i < bits.len(); i++) cyc(1'b1, bits[i] == "1");
  endtask

  // Transmitter-style keying: dot 1, dash 3, intra gap 1, letter gap 3.
  task automatic send_pattern(input string p);
    for (int i = 0; i < p.len(); i++) begin
      if (p[i] == "-") send_bits("111");
      else             send_bits("1");
      if (i != p.len() - 1) send_bits("0");
    end
    send_bits("000");
  endtask

  task automatic unit_rand(input logic d, input int max_idle);
    int n;
    n = $urandom_range(0, max_idle);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)));
    cyc(1'b1, d);
  endtask

  task automatic send_rand_letter();
    int nsyms, len, gap;
    string p;
    bit garbage;
    garbage = ($urandom_range(0, 4) == 0);
    if (garbage) begin
      nsyms = $urandom_range(1, 5);
      p = "";
      for (int i = 0; i < nsyms; i++) p = {p, "x"};
    end else begin
      p = codes[$urandom_range(0, 7)];
    end
    for (int i = 0; i < p.len(); i++) begin
      if (garbage) len = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 18) : $urandom_range(1, 6);
      else if (p[i] == "-") len = $urandom_range(2, 3);
      else len = 1;
      for (int j = 0; j < len; j++) unit_rand(1'b1, 2);
      if (i != p.len() - 1) begin
        gap = $urandom_range(1, 2);
        for (int j = 0; j < gap; j++) unit_rand(1'b0, 2);
      end
    end
    gap = $urandom_range(3, 5);
    for (int j = 0; j < gap; j++) unit_rand(1'b0, 2);
  endtask

  int base;

  initial begin
    model_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_error", int'(error), 0);
    check("rst_lettercode", int'(lettercode), 0);
    reset = 1'b0;
    cyc(1'b0, 1'b0);

    base = n_valid_seen;
    send_bits("10101000");
    check("S_code", int'(lettercode), 0);
    check("S_valid_cnt", n_valid_seen - base, 1);

    base = n_valid_seen;
    send_bits("11101110101000");
    check("Z_code", int'(lettercode), 7);
    send_pattern("-.--");
    check("Y_code", int'(lettercode), 6);
    send_pattern("-..-");
    check("X_code", int'(lettercode), 5);
    check("ZYX_valid_cnt", n_valid_seen - base, 3);

    base = n_valid_seen;
    send_bits("1111000");
    send_bits("111000");
    check("T_code", int'(lettercode), 1);
    check("long_T_valid_cnt", n_valid_seen - base, ERR_EN ? 1 : 2);

    base = n_valid_seen;
    send_bits("1000");
    check("E_valid_cnt", n_valid_seen - base, 0);
    check("E_code_held", int'(lettercode), 1);

    // Reset in the middle of a W: partial symbols must be discarded.
    send_bits("10111");
    reset = 1'b1;
    #2;
    check("midrst_lettercode", int'(lettercode), 0);
    @(posedge clock);
    #1;
    model_reset();
    check("midrst_valid", int'(valid), 0);
    check("midrst_error", int'(error), 0);
    reset = 1'b0;
    base = n_valid_seen;
    send_pattern("..-");
    check("U_code", int'(lettercode), 2);
    check("U_valid_cnt", n_valid_seen - base, 1);

    // din toggling without ticks in the middle of an S.
    base = n_valid_seen;
    send_bits("10");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2));
    send_bits("101000");
    check("S2_code", int'(lettercode), 0);
    check("S2_valid_cnt", n_valid_seen - base, 1);

    for (int c = 0; c < 8; c++) begin
      send_pattern(codes[c]);
      check("loop_code", int'(lettercode), c);
    end

    for (int n = 0; n < 300; n++) send_rand_letter();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
